// File: rtl/layer_readback_if.sv
// layer_readback_if: request, status, layer-memory read port and output stream of the readback engine.
interface layer_readback_if;
  logic        start;
  logic [2:0]  cfg_sel;
  logic [11:0] cfg_base;
  logic [12:0] cfg_len;
  logic        busy;
  logic        done;
  logic        err;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd;
  logic        o_valid;
  logic [19:0] o_data;
  logic        o_last;
  logic        i_ready;
  modport master (
    output start, cfg_sel, cfg_base, cfg_len, cdata_rd, i_ready,
    input  busy, done, err, crd, caddr_rd, csel, o_valid, o_data, o_last
  );
  modport slave (
    input  start, cfg_sel, cfg_base, cfg_len, cdata_rd, i_ready,
    output busy, done, err, crd, caddr_rd, csel, o_valid, o_data, o_last
  );
endinterface

// File: rtl/layer_readback.sv
// layer_readback: streams cfg_len words of a layer memory from cfg_base through a registered head plus 2-entry FIFO.
module layer_readback (
  input logic clk,
  input logic reset,
  layer_readback_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [2:0] sel_q, sel_d, csel_q, csel_d;
  logic [11:0] addr_q, addr_d, caddr_q, caddr_d, rd_addr;
  logic [12:0] left_q, left_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, crd_q, crd_d;
  logic last_q, last_d, cap_q, caplast_q;
  logic ov_q, ov_d, ol_q, ol_d;
  logic [19:0] od_q, od_d;
  logic [19:0] sd_q [2];
  logic [19:0] sd_d [2];
  logic sl_q [2];
  logic sl_d [2];
  logic [1:0] sc_q, sc_d;
  logic legal, pop, room, issue, fin, to_head;
  assign legal = bus.cfg_len != 13'd0 && bus.cfg_sel != 3'd0 && bus.cfg_sel < 3'd6;
  assign pop = ov_q & bus.i_ready;
  assign fin = pop & ol_q;
  // head + FIFO + both read pipeline stages may hold at most 3 words once this cycle's pop retires
  assign room = 3'(sc_q) + 3'(ov_q) + 3'(cap_q) + 3'(crd_q) < 3'd3 + 3'(pop);
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = !bus.start ? IDLE : !legal ? DONE : bus.cfg_len == 13'd1 ? DRAIN : READ;
      READ: state_d = room && left_q == 13'd1 ? DRAIN : READ;
      DRAIN: state_d = fin ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    issue = state_q == IDLE ? bus.start & legal : state_q == READ & room;
    rd_addr = state_q == IDLE ? bus.cfg_base : addr_q;
    crd_d = issue;
    caddr_d = issue ? rd_addr : '0;
    addr_d = issue ? rd_addr + 12'd1 : addr_q;
    left_d = issue ? (state_q == IDLE ? bus.cfg_len : left_q) - 13'd1 : left_q;
    last_d = issue & (state_q == IDLE ? bus.cfg_len == 13'd1 : left_q == 13'd1);
    sel_d = state_q == IDLE && bus.start ? bus.cfg_sel : sel_q;
    busy_d = state_d == READ || state_d == DRAIN;
    csel_d = busy_d ? sel_d : '0;
    done_d = state_d == DONE;
    err_d = state_q == IDLE && state_d == DONE;
  end
  // returning word goes straight to the head only when nothing older is queued behind it
  always_comb begin
    ov_d = ov_q;
    ol_d = ol_q;
    od_d = od_q;
    sd_d = sd_q;
    sl_d = sl_q;
    sc_d = sc_q;
    to_head = (!ov_q || pop) && sc_q == 2'd0;
    if ((!ov_q || pop) && sc_q != 2'd0) begin
      ov_d = 1'b1;
      od_d = sd_q[0];
      ol_d = sl_q[0];
      sd_d[0] = sd_q[1];
      sl_d[0] = sl_q[1];
      sc_d = sc_q - 2'd1;
    end else if (to_head) begin
      ov_d = cap_q;
      ol_d = cap_q & caplast_q;
      od_d = cap_q ? bus.cdata_rd : od_q;
    end
    if (cap_q && !to_head) begin
      sd_d[sc_d[0]] = bus.cdata_rd;
      sl_d[sc_d[0]] = caplast_q;
      sc_d = sc_d + 2'd1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sel_q <= '0;
      csel_q <= '0;
      addr_q <= '0;
      caddr_q <= '0;
      left_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      crd_q <= 1'b0;
      last_q <= 1'b0;
      cap_q <= 1'b0;
      caplast_q <= 1'b0;
      ov_q <= 1'b0;
      ol_q <= 1'b0;
      od_q <= '0;
      sd_q <= '{default: '0};
      sl_q <= '{default: 1'b0};
      sc_q <= '0;
    end else begin
      sel_q <= sel_d;
      csel_q <= csel_d;
      addr_q <= addr_d;
      caddr_q <= caddr_d;
      left_q <= left_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      crd_q <= crd_d;
      last_q <= last_d;
      cap_q <= crd_q;
      caplast_q <= last_q;
      ov_q <= ov_d;
      ol_q <= ol_d;
      od_q <= od_d;
      sd_q <= sd_d;
      sl_q <= sl_d;
      sc_q <= sc_d;
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.crd = crd_q;
  assign bus.caddr_rd = caddr_q;
  assign bus.csel = csel_q;
  assign bus.o_valid = ov_q;
  assign bus.o_data = od_q;
  assign bus.o_last = ol_q;
endmodule
